uart_cfg_rx: RTL and testbench

Addressed UART configuration receiver: the parametrised successor of the sequential-fill config receiver. It deserialises 8N1 frames, or 8E1 frames when parity is enabled, from the host link. Frames are paired into (index, value) packets, and each packet writes one of `PAR_NUM` parameter registers that drive the controller (ref_gen, phase_shift, ocd_lvl, inter_freq, inter_duty, …). It adds input synchronisation, false-start rejection, stop-bit checking, index range checking, an inter-frame timeout and an update strobe.

---
 rtl/uart_cfg_rx.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_cfg_rx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_cfg_rx.sv
// Addressed UART config receiver: (index, value) frame pairs write PAR_NUM registers.
// Optional even parity bit when UART_PARITY_EN is defined.
module uart_cfg_rx #(
    parameter int CLK_DIV      = 52,
    parameter int DATA_BITS    = 8,
    parameter int PAR_NUM      = 5,
    parameter int TIMEOUT_BITS = 20,
    localparam int IW = (PAR_NUM > 1) ? $clog2(PAR_NUM) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         uart_data,
    output logic [PAR_NUM*DATA_BITS-1:0] par_bus,
    output logic                         upd_stb,
    output logic [IW-1:0]                upd_idx,
    output logic                         frame_err,
    output logic                         addr_err,
    output logic                         par_err
);
    localparam int CW     = $clog2(CLK_DIV);
    localparam int BW     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int TO_LIM = TIMEOUT_BITS * CLK_DIV;
    localparam int TW     = $clog2(TO_LIM + 1);

    typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_PAR, B_STOP} bst_t;
    typedef enum logic {P_IDX, P_VAL} pst_t;

    logic [1:0]                   r_sync;
    logic                         r_rx_d;
    bst_t                         r_bst, w_bst_nxt;
    logic [CW-1:0]                r_cnt, w_cnt_nxt;
    logic [BW-1:0]                r_bitn, w_bitn_nxt;
    logic [DATA_BITS-1:0]         r_shift, w_shift_nxt;
    pst_t                         r_pst, w_pst_nxt;
    logic [TW-1:0]                r_tcnt, w_tcnt_nxt;
    logic [IW-1:0]                r_idx;
    logic [PAR_NUM*DATA_BITS-1:0] r_par_bus;
    logic [IW-1:0]                r_upd_idx;
    logic                         r_upd_stb, r_frame_err, r_addr_err, r_par_err;
    logic                         w_rx_s, w_fall, w_zero, w_start, w_done, w_stop_ok;
    logic                         w_ferr, w_perr, w_valid, w_in_range, w_latch, w_wr;
`ifdef UART_PARITY_EN
    logic                         r_par, w_par_nxt;
`endif

    assign w_rx_s     = r_sync[1];
    assign w_fall     = r_rx_d & ~w_rx_s;
    assign w_zero     = (r_cnt == '0);
    assign w_in_range = (32'(r_shift) < 32'(PAR_NUM));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
            r_rx_d <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], uart_data};
            r_rx_d <= r_sync[1];
        end
    end

    always_comb begin
        w_bst_nxt   = r_bst;
        w_cnt_nxt   = r_cnt;
        w_bitn_nxt  = r_bitn;
        w_shift_nxt = r_shift;
`ifdef UART_PARITY_EN
        w_par_nxt   = r_par;
`endif
        w_start     = 1'b0;
        w_done      = 1'b0;
        w_stop_ok   = 1'b0;
        unique case (r_bst)
            B_IDLE: begin
                if (w_fall) begin
                    w_bst_nxt = B_START;
                    w_cnt_nxt = CW'(CLK_DIV / 2 - 1);
                    w_start   = 1'b1;
                end
            end
            B_START: begin
                if (!w_zero) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (w_rx_s) begin
                    w_bst_nxt = B_IDLE;
                end else begin
                    w_bst_nxt  = B_DATA;
                    w_cnt_nxt  = CW'(CLK_DIV - 1);
                    w_bitn_nxt = '0;
                end
            end
            B_DATA: begin
                if (!w_zero) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    w_cnt_nxt   = CW'(CLK_DIV - 1);
                    w_bitn_nxt  = r_bitn + 1'b1;
                    if (r_bitn == BW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                        w_bst_nxt = B_PAR;
`else
                        w_bst_nxt = B_STOP;
`endif
                    end
                end
            end
            B_PAR: begin
                if (!w_zero) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
`ifdef UART_PARITY_EN
                    w_par_nxt = w_rx_s;
`endif
                    w_bst_nxt = B_STOP;
                    w_cnt_nxt = CW'(CLK_DIV - 1);
                end
            end
            B_STOP: begin
                if (!w_zero) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_done    = 1'b1;
                    w_stop_ok = w_rx_s;
                    w_bst_nxt = B_IDLE;
                end
            end
            default: w_bst_nxt = B_IDLE;
        endcase
    end

    // A bad stop bit takes precedence over a parity mismatch
    assign w_ferr = w_done & ~w_stop_ok;
`ifdef UART_PARITY_EN
    assign w_perr = w_done & w_stop_ok & (r_par != ^r_shift);
`else
    assign w_perr = 1'b0;
`endif
    assign w_valid = w_done & w_stop_ok & ~w_perr;

    always_comb begin
        w_pst_nxt  = r_pst;
        w_tcnt_nxt = r_tcnt;
        w_latch    = 1'b0;
        w_wr       = 1'b0;
        unique case (r_pst)
            P_IDX: begin
                w_tcnt_nxt = '0;
                if (w_valid && w_in_range) begin
                    w_latch   = 1'b1;
                    w_pst_nxt = P_VAL;
                end
            end
            P_VAL: begin
                if (w_start)
                    w_tcnt_nxt = '0;
                else if (r_bst == B_IDLE && r_tcnt != TW'(TO_LIM))
                    w_tcnt_nxt = r_tcnt + 1'b1;
                if (w_valid) begin
                    w_wr      = 1'b1;
                    w_pst_nxt = P_IDX;
                end else if (w_ferr || w_perr) begin
                    w_pst_nxt = P_IDX;
                end else if (r_tcnt == TW'(TO_LIM) && !w_start) begin
                    w_pst_nxt = P_IDX;
                end
            end
            default: w_pst_nxt = P_IDX;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bst   <= B_IDLE;
            r_cnt   <= '0;
            r_bitn  <= '0;
            r_shift <= '0;
`ifdef UART_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_bst   <= w_bst_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bitn  <= w_bitn_nxt;
            r_shift <= w_shift_nxt;
`ifdef UART_PARITY_EN
            r_par   <= w_par_nxt;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pst       <= P_IDX;
            r_tcnt      <= '0;
            r_idx       <= '0;
            r_par_bus   <= '0;
            r_upd_idx   <= '0;
            r_upd_stb   <= 1'b0;
            r_frame_err <= 1'b0;
            r_addr_err  <= 1'b0;
            r_par_err   <= 1'b0;
        end else begin
            r_pst       <= w_pst_nxt;
            r_tcnt      <= w_tcnt_nxt;
            r_upd_stb   <= w_wr;
            r_frame_err <= w_ferr;
            r_par_err   <= w_perr;
            r_addr_err  <= (r_pst == P_IDX) && w_valid && !w_in_range;
            if (w_latch)
                r_idx <= r_shift[IW-1:0];
            if (w_wr) begin
                r_upd_idx <= r_idx;
                for (int i = 0; i < PAR_NUM; i++)
                    if (r_idx == IW'(i))
                        r_par_bus[i*DATA_BITS +: DATA_BITS] <= r_shift;
            end
        end
    end

    assign par_bus   = r_par_bus;
    assign upd_stb   = r_upd_stb;
    assign upd_idx   = r_upd_idx;
    assign frame_err = r_frame_err;
    assign addr_err  = r_addr_err;
    assign par_err   = r_par_err;
endmodule

// File: tb/tb_uart_cfg_rx.sv
// Testbench for uart_cfg_rx: table of (index, value) packets plus glitch,
// timeout, reset-abort and (with UART_PARITY_EN) parity-error sequences.
module tb_uart_cfg_rx;
    localparam int CD = 52;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_data = 1'b1;
    logic [39:0] par_bus;
    logic        upd_stb;
    logic [2:0]  upd_idx;
    logic        frame_err, addr_err, par_err;

    int n_err = 0;
    int n_chk = 0;
    int n_stb = 0, n_aerr = 0, n_ferr = 0, n_perr = 0;

    uart_cfg_rx #(
        .CLK_DIV(CD), .DATA_BITS(8), .PAR_NUM(5), .TIMEOUT_BITS(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .uart_data(uart_data),
        .par_bus(par_bus), .upd_stb(upd_stb), .upd_idx(upd_idx),
        .frame_err(frame_err), .addr_err(addr_err), .par_err(par_err)
    );

    always #5 clk = ~clk;

    // Each cycle high adds one, so a count of 1 per event also proves 1-cycle width
    always @(negedge clk) begin
        if (upd_stb)   n_stb  <= n_stb + 1;
        if (addr_err)  n_aerr <= n_aerr + 1;
        if (frame_err) n_ferr <= n_ferr + 1;
        if (par_err)   n_perr <= n_perr + 1;
    end

    typedef struct {
        logic [7:0]  f0;
        logic [7:0]  f1;
        bit          two;
        bit          f1_stop;
        int          gap;
        logic [39:0] bus;
        logic [2:0]  idx;
        int          stb;
        int          aerr;
        int          ferr;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        uart_data = b;
        repeat (CD) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_PARITY_EN
        send_bit((^d) ^ ~par_ok);
`endif
        send_bit(stop);
        uart_data = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        uart_data = 1'b1;
        repeat (n * CD) @(negedge clk);
    endtask

    int s_stb, s_aerr, s_ferr, s_perr;

    task automatic snap();
        s_stb  = n_stb;
        s_aerr = n_aerr;
        s_ferr = n_ferr;
        s_perr = n_perr;
    endtask

    initial begin
        vt[0]  = '{8'h02, 8'hA5, 1'b1, 1'b1, 0,  40'h00_00_A5_00_00, 3'd2, 1, 0, 0};
        vt[1]  = '{8'h07, 8'h00, 1'b0, 1'b1, 0,  40'h00_00_A5_00_00, 3'd2, 0, 1, 0};
        vt[2]  = '{8'h01, 8'h3C, 1'b1, 1'b1, 0,  40'h00_00_A5_3C_00, 3'd1, 1, 0, 0};
        vt[3]  = '{8'h00, 8'h77, 1'b1, 1'b0, 0,  40'h00_00_A5_3C_00, 3'd1, 0, 0, 1};
        vt[4]  = '{8'h33, 8'h00, 1'b0, 1'b1, 0,  40'h00_00_A5_3C_00, 3'd1, 0, 1, 0};
        vt[5]  = '{8'h04, 8'h81, 1'b1, 1'b1, 0,  40'h81_00_A5_3C_00, 3'd4, 1, 0, 0};
        vt[6]  = '{8'h03, 8'h55, 1'b1, 1'b1, 21, 40'h81_00_A5_3C_00, 3'd4, 0, 1, 0};
        vt[7]  = '{8'h00, 8'h5A, 1'b1, 1'b1, 0,  40'h81_00_A5_3C_5A, 3'd0, 1, 0, 0};
        vt[8]  = '{8'h02, 8'h00, 1'b1, 1'b1, 2,  40'h81_00_00_3C_5A, 3'd2, 1, 0, 0};
        vt[9]  = '{8'hFF, 8'h00, 1'b0, 1'b1, 0,  40'h81_00_00_3C_5A, 3'd2, 0, 1, 0};
        vt[10] = '{8'h05, 8'h00, 1'b0, 1'b1, 0,  40'h81_00_00_3C_5A, 3'd2, 0, 1, 0};
        vt[11] = '{8'h04, 8'h11, 1'b1, 1'b1, 0,  40'h11_00_00_3C_5A, 3'd4, 1, 0, 0};

        repeat (4) @(negedge clk);
        chk("reset_bus", 64'(par_bus), 64'h0);
        chk("reset_idx", 64'(upd_idx), 64'h0);
        chk("reset_pulses", 64'({upd_stb, addr_err, frame_err, par_err}), 64'h0);
        rst_n = 1'b1;
        idle_bits(2);

        for (int v = 0; v < 12; v++) begin
            snap();
            send_frame(vt[v].f0, 1'b1, 1'b1);
            if (vt[v].two) begin
                if (vt[v].gap > 0) idle_bits(vt[v].gap);
                send_frame(vt[v].f1, vt[v].f1_stop, 1'b1);
            end
            repeat (10) @(negedge clk);
            chk($sformatf("v%0d_bus", v), 64'(par_bus), 64'(vt[v].bus));
            chk($sformatf("v%0d_idx", v), 64'(upd_idx), 64'(vt[v].idx));
            chk($sformatf("v%0d_stb", v), 64'(n_stb - s_stb), 64'(vt[v].stb));
            chk($sformatf("v%0d_aerr", v), 64'(n_aerr - s_aerr), 64'(vt[v].aerr));
            chk($sformatf("v%0d_ferr", v), 64'(n_ferr - s_ferr), 64'(vt[v].ferr));
            idle_bits(1);
        end

        // Short low glitch must be rejected as a false start
        snap();
        uart_data = 1'b0;
        repeat (10) @(negedge clk);
        idle_bits(3);
        chk("glitch_pulses", 64'((n_stb - s_stb) + (n_aerr - s_aerr) + (n_ferr - s_ferr)), 64'h0);
        send_frame(8'h04, 1'b1, 1'b1);
        send_frame(8'h6B, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        chk("glitch_reg4", 64'(par_bus[39:32]), 64'h6B);
        chk("glitch_stb", 64'(n_stb - s_stb), 64'h1);
        idle_bits(1);

        // Reset in the middle of the value frame
        snap();
        send_frame(8'h01, 1'b1, 1'b1);
        fork
            send_frame(8'hFF, 1'b1, 1'b1);
            begin
                repeat (CD * 3 + 10) @(negedge clk);
                rst_n = 1'b0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        idle_bits(2);
        chk("rst_bus", 64'(par_bus), 64'h0);
        chk("rst_idx", 64'(upd_idx), 64'h0);
        chk("rst_stb", 64'(n_stb - s_stb), 64'h0);
        snap();
        send_frame(8'h03, 1'b1, 1'b1);
        send_frame(8'h99, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        chk("after_rst_bus", 64'(par_bus), 64'h00_99_00_00_00);
        chk("after_rst_idx", 64'(upd_idx), 64'h3);
        chk("after_rst_stb", 64'(n_stb - s_stb), 64'h1);
        idle_bits(1);

`ifdef UART_PARITY_EN
        snap();
        send_frame(8'h01, 1'b1, 1'b1);
        send_frame(8'h0F, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        chk("par_err_cnt", 64'(n_perr - s_perr), 64'h1);
        chk("par_reg1", 64'(par_bus[15:8]), 64'h0);
        chk("par_stb", 64'(n_stb - s_stb), 64'h0);
`else
        chk("par_err_tied", 64'(n_perr), 64'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
